// File: rtl/serial_slave.sv
// Mode-3 SPI byte responder: external master exchanges bytes with the host side.
// All serial pins are oversampled in the CLK domain; FCK is treated as data only.
module serial_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       WS,
  input  logic       RS,
  inout  wire  [7:0] DATA,
  input  logic       FCK,
  input  logic       FCS,
  input  logic       FSI,
  output logic       FSO,
  output logic       RXF,
  output logic       TXE,
  output logic       OVR
);

  logic [SYNC_STAGES-1:0] fck_sync_reg;
  logic [SYNC_STAGES-1:0] fcs_sync_reg;
  logic [SYNC_STAGES-1:0] fsi_sync_reg;
  logic                   fck_d_reg;

  logic       fck_s, fcs_s, fsi_s;
  logic       fck_fall, fck_rise;

  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] tx_hold_reg, tx_hold_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_reg, rx_next;
  logic       fso_reg, fso_next;
  logic       txe_reg, txe_next;
  logic       rxf_reg, rxf_next;
  logic       ovr_reg, ovr_next;
  logic       done_reg, done_next;
  logic [7:0] load_byte;

  // Synchronizer chains; idle levels on reset so no spurious edge appears on release.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      fck_sync_reg <= '1;
      fcs_sync_reg <= '1;
      fsi_sync_reg <= '0;
      fck_d_reg    <= 1'b1;
    end else begin
      fck_sync_reg <= {fck_sync_reg[SYNC_STAGES-2:0], FCK};
      fcs_sync_reg <= {fcs_sync_reg[SYNC_STAGES-2:0], FCS};
      fsi_sync_reg <= {fsi_sync_reg[SYNC_STAGES-2:0], FSI};
      fck_d_reg    <= fck_sync_reg[SYNC_STAGES-1];
    end
  end

  assign fck_s    = fck_sync_reg[SYNC_STAGES-1];
  assign fcs_s    = fcs_sync_reg[SYNC_STAGES-1];
  assign fsi_s    = fsi_sync_reg[SYNC_STAGES-1];
  assign fck_fall =  fck_d_reg & ~fck_s & ~fcs_s;
  assign fck_rise = ~fck_d_reg &  fck_s & ~fcs_s;

  // A byte boundary load takes the reply seen before any same-cycle host write.
  assign load_byte = txe_reg ? IDLE_FILL : tx_hold_reg;

  always_comb begin
    cnt_next      = cnt_reg;
    tx_shift_next = tx_shift_reg;
    tx_hold_next  = tx_hold_reg;
    rx_shift_next = rx_shift_reg;
    rx_next       = rx_reg;
    fso_next      = fso_reg;
    txe_next      = txe_reg;
    rxf_next      = rxf_reg;
    ovr_next      = ovr_reg;
    done_next     = 1'b0;

    if (fcs_s) begin
      cnt_next = 3'd0;
      fso_next = 1'b1;
    end else begin
      if (fck_fall) begin
        if (cnt_reg == 3'd0) begin
          tx_shift_next = load_byte;
          txe_next      = 1'b1;
          fso_next      = load_byte[7];
        end else begin
          tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          fso_next      = tx_shift_reg[6];
        end
      end
      if (fck_rise) begin
        rx_shift_next = {rx_shift_reg[6:0], fsi_s};
        cnt_next      = cnt_reg + 3'd1;
        done_next     = (cnt_reg == 3'd7);
      end
    end

    if (RS) begin
      rxf_next = 1'b0;
      ovr_next = 1'b0;
    end

    // A read in the same cycle frees the register, so the new byte is kept.
    if (done_reg) begin
      if (!rxf_reg || RS) begin
        rx_next  = rx_shift_reg;
        rxf_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end

    if (WS) begin
      tx_hold_next = DATA;
      txe_next     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_reg      <= 3'd0;
      tx_shift_reg <= 8'h00;
      tx_hold_reg  <= IDLE_FILL;
      rx_shift_reg <= 8'h00;
      rx_reg       <= 8'h00;
      fso_reg      <= 1'b1;
      txe_reg      <= 1'b1;
      rxf_reg      <= 1'b0;
      ovr_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      tx_shift_reg <= tx_shift_next;
      tx_hold_reg  <= tx_hold_next;
      rx_shift_reg <= rx_shift_next;
      rx_reg       <= rx_next;
      fso_reg      <= fso_next;
      txe_reg      <= txe_next;
      rxf_reg      <= rxf_next;
      ovr_reg      <= ovr_next;
      done_reg     <= done_next;
    end
  end

  assign DATA = RS ? rx_reg : 8'hzz;
  assign FSO  = fso_reg;
  assign TXE  = txe_reg;
  assign RXF  = rxf_reg;
  assign OVR  = ovr_reg;

endmodule

// File: tb/tb_serial_slave.sv
// Bench for serial_slave: drives a mode-3 master at CLK/8 and checks against a byte-level model.
module tb_serial_slave;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       WS = 1'b0;
  logic       RS = 1'b0;
  logic       FCK = 1'b1;
  logic       FCS = 1'b1;
  logic       FSI = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic       tb_den = 1'b0;
  wire  [7:0] DATA;
  logic       FSO, RXF, TXE, OVR;

  int checks = 0;
  int errors = 0;

  // Byte-level model of the host-visible state
  logic [7:0] m_hold, m_rx;
  logic       m_txe, m_rxf, m_ovr;

  assign DATA = tb_den ? tb_data : 8'hzz;

  serial_slave #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .CLK(CLK), .RSTn(RSTn), .WS(WS), .RS(RS), .DATA(DATA),
    .FCK(FCK), .FCS(FCS), .FSI(FSI), .FSO(FSO),
    .RXF(RXF), .TXE(TXE), .OVR(OVR)
  );

  always #4 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    m_hold = 8'hFF;
    m_txe  = 1'b1;
    m_rx   = 8'h00;
    m_rxf  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_load(output logic [7:0] r);
    r     = m_txe ? 8'hFF : m_hold;
    m_txe = 1'b1;
  endtask

  task automatic model_rx_done(input logic [7:0] b);
    if (!m_rxf) begin
      m_rx  = b;
      m_rxf = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_flags(input string name);
    checks++;
    if ({RXF, OVR, TXE} !== {m_rxf, m_ovr, m_txe}) begin
      errors++;
      $display("FAIL %s flags: RXF/OVR/TXE got %b%b%b expected %b%b%b",
               name, RXF, OVR, TXE, m_rxf, m_ovr, m_txe);
    end
  endtask

  task automatic host_write(input logic [7:0] v);
    tb_data = v;
    tb_den  = 1'b1;
    WS      = 1'b1;
    clk_n(1);
    WS      = 1'b0;
    tb_den  = 1'b0;
    m_hold  = v;
    m_txe   = 1'b0;
    $display("write  %02h", v);
  endtask

  task automatic host_read(input string name);
    logic [7:0] got;
    RS = 1'b1;
    #1;
    got = DATA;
    checks++;
    if (got !== m_rx) begin
      errors++;
      $display("FAIL %s read: got %h expected %h", name, got, m_rx);
    end
    clk_n(1);
    RS    = 1'b0;
    m_rxf = 1'b0;
    m_ovr = 1'b0;
    $display("read   %02h (expected %02h)", got, m_rx);
    check_flags({name, "_after_read"});
  endtask

  task automatic frame_start();
    FCS = 1'b0;
    clk_n(4);
  endtask

  task automatic frame_end(input string name);
    FCS = 1'b1;
    clk_n(4);
    checks++;
    if (FSO !== 1'b1) begin
      errors++;
      $display("FAIL %s idle FSO: got %b expected 1", name, FSO);
    end
  endtask

  // Master bit engine; optionally pulses WS on the CLK where the first fall is acted on.
  task automatic send_bits(input logic [7:0] mosi, input int nbits, input logic ws_fire,
                           input logic [7:0] ws_val, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      FCK = 1'b0;
      FSI = mosi[7-i];
      if (i == 0 && ws_fire) begin
        clk_n(2);
        tb_data = ws_val;
        tb_den  = 1'b1;
        WS      = 1'b1;
        clk_n(1);
        WS      = 1'b0;
        tb_den  = 1'b0;
        clk_n(1);
      end else begin
        clk_n(4);
      end
      miso = {miso[6:0], FSO};
      FCK  = 1'b1;
      clk_n(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] mosi, input logic ws_fire, input logic [7:0] ws_val,
                           input string name);
    logic [7:0] exp_reply, miso;
    model_load(exp_reply);
    if (ws_fire) begin
      m_hold = ws_val;
      m_txe  = 1'b0;
    end
    send_bits(mosi, 8, ws_fire, ws_val, miso);
    model_rx_done(mosi);
    $display("byte   mosi %02h miso %02h (expected %02h)", mosi, miso, exp_reply);
    checks++;
    if (miso !== exp_reply) begin
      errors++;
      $display("FAIL %s miso: got %h expected %h", name, miso, exp_reply);
    end
    check_flags(name);
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    FCK = 1'b1; FCS = 1'b1; WS = 1'b0; RS = 1'b0; tb_den = 1'b0;
    clk_n(3);
    RSTn = 1'b1;
    clk_n(2);
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    check_flags("reset");
    checks++;
    if (FSO !== 1'b1) begin
      errors++;
      $display("FAIL reset FSO: got %b expected 1", FSO);
    end
    host_read("reset");
  endtask

  task automatic test_basic();
    host_write(8'hA5);
    check_flags("basic_ws");
    frame_start();
    send_byte(8'h3C, 1'b0, 8'h00, "basic");
    frame_end("basic");
    host_read("basic");
  endtask

  task automatic test_idle_fill();
    frame_start();
    send_byte(8'h00, 1'b0, 8'h00, "idle_fill");
    frame_end("idle_fill");
    host_read("idle_fill");
  endtask

  task automatic test_overrun();
    frame_start();
    send_byte(8'h11, 1'b0, 8'h00, "overrun_b1");
    send_byte(8'h22, 1'b0, 8'h00, "overrun_b2");
    frame_end("overrun");
    check_flags("overrun");
    host_read("overrun");
  endtask

  task automatic test_abort();
    logic [7:0] dummy, miso;
    frame_start();
    model_load(dummy);
    send_bits(8'hFF, 5, 1'b0, 8'h00, miso);
    frame_end("abort");
    check_flags("abort_partial");
    frame_start();
    send_byte(8'h81, 1'b0, 8'h00, "abort_full");
    frame_end("abort_full");
    host_read("abort");
  endtask

  task automatic test_ws_coincident();
    frame_start();
    send_byte(8'hAA, 1'b1, 8'h5A, "ws_coinc_b1");
    host_read("ws_coinc_b1");
    send_byte(8'h55, 1'b0, 8'h00, "ws_coinc_b2");
    frame_end("ws_coinc");
    host_read("ws_coinc_b2");
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] dummy, miso;
    host_write(8'h77);
    frame_start();
    model_load(dummy);
    send_bits(8'hC3, 4, 1'b0, 8'h00, miso);
    RSTn = 1'b0;
    clk_n(2);
    model_reset();
    check_flags("midreset");
    checks++;
    if (FSO !== 1'b1) begin
      errors++;
      $display("FAIL midreset FSO: got %b expected 1", FSO);
    end
    FCS = 1'b1;
    clk_n(2);
    RSTn = 1'b1;
    clk_n(4);
    check_flags("midreset_release");
    frame_start();
    send_byte(8'hC3, 1'b0, 8'h00, "midreset_byte");
    frame_end("midreset_byte");
    host_read("midreset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int nb;
      frame_start();
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 2) == 0) host_write(8'($urandom));
        send_byte(8'($urandom), 1'b0, 8'h00, "random");
        if ($urandom_range(0, 1) == 1) host_read("random_mid");
      end
      frame_end("random");
      if ($urandom_range(0, 1) == 1) host_read("random_end");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_idle_fill();
    test_overrun();
    test_abort();
    test_ws_coincident();
    test_reset_midbyte();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
